serial_subtractor: RTL and testbench

- Multi-cycle WIDTH-bit subtractor with borrow-in and borrow-out: computes A - B - Bin one SLICE_W-bit slice per cycle, least significant slice first.
- Pairs with the single-cycle carry adder in the arithmetic datapath library.
- Provides a registered valid/ready handshake on both sides so the ALU and iterative units can schedule it.
- Also produces the zero and signed-overflow flags.

---
 rtl/serial_subtractor.sv | 79 +++++++
 tb/tb_serial_subtractor.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: A - B - Bin computed one SLICE_W-bit slice per cycle with valid/ready handshakes.
// The borrow ripples between slices only through the borrow register.
module serial_subtractor #(
   parameter int WIDTH   = 32,
   parameter int SLICE_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] D,
   output logic             Bout,
   output logic             Z,
   output logic             V
);
   localparam int N = WIDTH / SLICE_W;
   localparam int KW = N > 1 ? $clog2(N) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state;
   logic [WIDTH-1:0] a_r, b_r, d_next;
   logic [KW-1:0] k;
   logic borrow;
   logic [SLICE_W:0] diff;
   assign in_ready = state == IDLE && !rst;
   always_comb begin
      diff = {1'b0, a_r[int'(k)*SLICE_W +: SLICE_W]} - {1'b0, b_r[int'(k)*SLICE_W +: SLICE_W]}
             - (SLICE_W+1)'(borrow);
      d_next = D;
      d_next[int'(k)*SLICE_W +: SLICE_W] = diff[SLICE_W-1:0];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         k         <= '0;
         borrow    <= 1'b0;
         a_r       <= '0;
         b_r       <= '0;
         out_valid <= 1'b0;
         D         <= '0;
         Bout      <= 1'b0;
         Z         <= 1'b0;
         V         <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_r    <= A;
               b_r    <= B;
               borrow <= Bin;
               k      <= '0;
               state  <= RUN;
            end
            RUN: begin
               D      <= d_next;
               borrow <= diff[SLICE_W];
               k      <= k + 1'b1;
               if (k == K_LAST) begin
                  Bout      <= diff[SLICE_W];
                  Z         <= d_next == '0;
                  // overflow only when operand signs differ and the result sign departs from A's
                  V         <= (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (d_next[WIDTH-1] ^ a_r[WIDTH-1]);
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor with 8-bit and 32-bit slices.
module tb_serial_subtractor;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [31:0] A = '0, B = '0;
   logic Bin = 1'b0;
   logic iv8 = 1'b0, or8 = 1'b0, ir8, ov8, bo8, z8, v8;
   logic iv32 = 1'b0, or32 = 1'b0, ir32, ov32, bo32, z32, v32;
   logic [31:0] d8, d32;
   int pass = 0, total = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(32), .SLICE_W(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .A(A), .B(B), .Bin(Bin),
      .out_valid(ov8), .out_ready(or8), .D(d8), .Bout(bo8), .Z(z8), .V(v8));
   serial_subtractor #(.WIDTH(32), .SLICE_W(32)) dut32 (
      .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .A(A), .B(B), .Bin(Bin),
      .out_valid(ov32), .out_ready(or32), .D(d32), .Bout(bo32), .Z(z32), .V(v32));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one operation on the chosen instance; lat counts edges after the accept edge until out_valid.
   task automatic run_op(input bit w32, input logic [31:0] a, input logic [31:0] b, input logic bin,
                         input bit rnd_ready, output int lat, output logic [34:0] res);
      A = a; B = b; Bin = bin;
      if (w32) iv32 = 1'b1; else iv8 = 1'b1;
      step();
      iv32 = 1'b0; iv8 = 1'b0;
      lat = 0;
      while ((w32 ? ov32 : ov8) !== 1'b1 && lat < 20) begin
         step();
         lat++;
      end
      res = w32 ? {d32, bo32, z32, v32} : {d8, bo8, z8, v8};
      for (int i = 0; i < 50; i++) begin
         logic r;
         r = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (w32) or32 = r; else or8 = r;
         step();
         if (r) break;
      end
      or32 = 1'b0; or8 = 1'b0;
   endtask

   task automatic test_reset();
      step();
      step();
      total++;
      if ({ir8, ov8, d8, bo8, z8, v8} !== 37'd0) $display("FAIL reset_state got ir=%b ov=%b d=%h bo=%b z=%b v=%b want all 0", ir8, ov8, d8, bo8, z8, v8);
      else pass++;
      rst = 1'b0;
      #1;
      total++;
      if (ir8 !== 1'b1) $display("FAIL reset_release_ready got %b want 1", ir8);
      else pass++;
   endtask

   task automatic test_basic();
      A = 32'd5; B = 32'd3; Bin = 1'b0; iv8 = 1'b1;
      step();
      iv8 = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         step();
         total++;
         if (ir8 !== 1'b0) $display("FAIL basic_in_ready edge %0d got %b want 0", e, ir8);
         else pass++;
         total++;
         if (ov8 !== (e == 4)) $display("FAIL basic_latency edge %0d out_valid got %b want %b", e, ov8, e == 4);
         else pass++;
      end
      total++;
      if ({d8, bo8, z8, v8} !== {32'h2, 3'b000}) $display("FAIL basic_result got d=%h bo=%b z=%b v=%b want d=00000002 bo=0 z=0 v=0", d8, bo8, z8, v8);
      else pass++;
      or8 = 1'b1;
      step();
      or8 = 1'b0;
   endtask

   task automatic test_vectors();
      logic [31:0] va [6] = '{32'h0, 32'h80000000, 32'h7FFFFFFF, 32'h100, 32'h0, 32'd10};
      logic [31:0] vb [6] = '{32'h1, 32'h1, 32'hFFFFFFFF, 32'hFF, 32'h0, 32'd20};
      logic        vc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [34:0] ve [6] = '{{32'hFFFFFFFF, 3'b100}, {32'h7FFFFFFF, 3'b001}, {32'h80000000, 3'b101},
                              {32'h0, 3'b010}, {32'hFFFFFFFF, 3'b100}, {32'hFFFFFFF6, 3'b100}};
      int lat;
      logic [34:0] res;
      for (int i = 0; i < 6; i++) begin
         run_op(1'b0, va[i], vb[i], vc[i], 1'b0, lat, res);
         total++;
         if (lat != 4) $display("FAIL vec%0d_latency got %0d want 4", i, lat);
         else pass++;
         total++;
         if (res !== ve[i]) $display("FAIL vec%0d_result got {d,bo,z,v}=%h want %h", i, res, ve[i]);
         else pass++;
      end
   endtask

   task automatic test_backpressure();
      logic [34:0] held;
      A = 32'h7FFFFFFF; B = 32'hFFFFFFFF; Bin = 1'b0; iv8 = 1'b1;
      step();
      iv8 = 1'b0;
      for (int i = 0; i < 20 && ov8 !== 1'b1; i++) step();
      held = {d8, bo8, z8, v8};
      total++;
      if (held !== {32'h80000000, 3'b101}) $display("FAIL bp_result got %h want %h", held, {32'h80000000, 3'b101});
      else pass++;
      for (int i = 0; i < 5; i++) begin
         A = $urandom; B = $urandom; Bin = i[0]; iv8 = ~iv8;
         step();
         total++;
         if ({d8, bo8, z8, v8} !== held || ov8 !== 1'b1 || ir8 !== 1'b0)
            $display("FAIL bp_hold cycle %0d got {d,bo,z,v}=%h ov=%b ir=%b want %h ov=1 ir=0", i, {d8, bo8, z8, v8}, ov8, ir8, held);
         else pass++;
      end
      iv8 = 1'b1;
      or8 = 1'b1;
      step();
      or8 = 1'b0;
      iv8 = 1'b0;
      total++;
      if (ov8 !== 1'b0 || ir8 !== 1'b1) $display("FAIL bp_release got ov=%b ir=%b want ov=0 ir=1", ov8, ir8);
      else pass++;
      total++;
      if ({d8, bo8, z8, v8} !== held) $display("FAIL bp_idle_hold got %h want %h", {d8, bo8, z8, v8}, held);
      else pass++;
   endtask

   task automatic test_mid_reset();
      A = 32'h12345678; B = 32'h1; Bin = 1'b0; iv8 = 1'b1;
      step();
      iv8 = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      total++;
      if (ov8 !== 1'b0 || d8 !== 32'h0 || ir8 !== 1'b1 || bo8 !== 1'b0)
         $display("FAIL mid_reset got ov=%b d=%h ir=%b bo=%b want ov=0 d=00000000 ir=1 bo=0", ov8, d8, ir8, bo8);
      else pass++;
      step();
      total++;
      if (ov8 !== 1'b0 || ir8 !== 1'b1) $display("FAIL mid_reset_idle got ov=%b ir=%b want ov=0 ir=1", ov8, ir8);
      else pass++;
   endtask

   task automatic test_random();
      int lat;
      logic [34:0] res, exp;
      logic [32:0] r;
      longint sr;
      for (int n = 0; n < 10000; n++) begin
         bit w32;
         logic [31:0] a, b;
         logic c;
         w32 = n >= 5000;
         a = $urandom; b = $urandom; c = 1'($urandom);
         if (n % 97 == 0) a = 32'h80000000;
         if (n % 89 == 0) b = a;
         r = {1'b0, a} - {1'b0, b} - 33'(c);
         sr = longint'($signed(a)) - longint'($signed(b)) - longint'(c);
         exp = {r[31:0], r[32], r[31:0] == 32'h0, sr > 64'sd2147483647 || sr < -64'sd2147483648};
         run_op(w32, a, b, c, 1'b1, lat, res);
         total++;
         if (lat != (w32 ? 1 : 4) || res !== exp)
            $display("FAIL random%0d w%0d a=%h b=%h bin=%b got lat=%0d res=%h want lat=%0d res=%h", n, w32 ? 32 : 8, a, b, c, lat, res, w32 ? 1 : 4, exp);
         else pass++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_vectors();
      test_backpressure();
      test_mid_reset();
      test_random();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
